pc_unit: RTL and testbench

//  Parametrised program-counter unit: PC register plus next-PC logic in one block.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_unit.sv | 135 +++++++++++++
 tb/tb_pc_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   pc_sel_e : next-PC source select produced by the top-level decode
//   DEFAULT_* : default parameter values for pc_unit
package pc_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 16;
  localparam int unsigned DEFAULT_INC          = 2;
  localparam int unsigned DEFAULT_SHIFT        = 1;
  localparam int unsigned DEFAULT_RESET_VECTOR = 0;
  localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with sticky overflow/underflow flags.
// A push into a full stack overwrites the oldest entry; a pop from an empty
// stack leaves the stack untouched and only raises the underflow flag.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   push, pop      : one-cycle requests (caller guarantees not both at once)
//   push_data      : address to store on push
//   top            : most recently pushed entry (valid when !empty)
//   empty          : no entries held
//   overflow       : sticky, push while full
//   underflow      : sticky, pop while empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             full;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // wr_ptr points at the next free slot; the top lives one below, modulo DEPTH.
  assign top   = mem[wr_ptr - PW'(1)];

  // Pointer, occupancy and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr - PW'(1);
        count  <= count - CW'(1);
      end
    end
  end

  // Entry storage; contents need no reset since count gates their use.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register plus next-PC selection for the fetch stage.
// Optional feature macro: PC_RAS_EN (internal return-address stack).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   stall               : hold PC and all state this cycle
//   signext             : sign-extended branch offset in instruction words
//   branch / branch_ne  : beq / bne, qualified by alu_zero (beq wins if both)
//   jump, call, ret     : absolute jump, call with link, return
//   jump_target         : absolute target for jump/call
//   ret_target          : register-supplied return address
//   pc                  : current PC (registered)
//   pc_next             : value pc takes at the next edge (combinational)
//   link_addr           : pc+INC (combinational), writeback value for call
//   ras_overflow/underflow : sticky stack flags (0 without PC_RAS_EN)
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned INC          = DEFAULT_INC,
  parameter int unsigned SHIFT        = DEFAULT_SHIFT,
  parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] signext,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             alu_zero,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] ret_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] link_addr,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] RV    = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_unit: RAS_DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] ret_dest;
  logic             br_taken;
  pc_sel_e          sel;

  // Sequential and branch targets; all arithmetic wraps modulo 2^WIDTH.
  assign pc_inc    = pc + INC_W;
  assign br_target = pc_inc + (signext << SHIFT);
  assign link_addr = pc_inc;

  // beq takes precedence: when branch is set, branch_ne is not consulted.
  assign br_taken = branch ? alu_zero : (branch_ne & ~alu_zero);

  // Next-PC source priority: stall > ret > call/jump > taken branch > increment.
  always_comb begin
    sel = SEL_INC;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call || jump) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end
  end

  // Next-PC mux; reset overrides everything.
  always_comb begin
    pc_next = pc_inc;
    if (reset) begin
      pc_next = RV;
    end else begin
      case (sel)
        SEL_HOLD: pc_next = pc;
        SEL_RET:  pc_next = ret_dest;
        SEL_JMP:  pc_next = jump_target;
        SEL_BR:   pc_next = br_target;
        default:  pc_next = pc_inc;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RV;
    end else begin
      pc <= pc_next;
    end
  end

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             do_push;
  logic             do_pop;

  // A stalled call/ret has no side effect; ret suppresses a simultaneous call.
  assign do_push = call & ~ret & ~stall;
  assign do_pop  = ret & ~stall;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Empty stack falls back to the register-supplied address.
  assign ret_dest = ras_empty ? ret_target : ras_top;
`else
  assign ret_dest      = ret_target;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (WIDTH=16, INC=2, SHIFT=1,
// RESET_VECTOR=0, RAS_DEPTH=4). Expected PC/flag values are queued when a
// step is driven and popped after the following rising edge.
module tb_pc_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [15:0] signext;
  logic        branch;
  logic        branch_ne;
  logic        alu_zero;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] jump_target;
  logic [15:0] ret_target;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] link_addr;
  logic        ras_overflow;
  logic        ras_underflow;

  pc_unit #(
    .WIDTH        (16),
    .INC          (2),
    .SHIFT        (1),
    .RESET_VECTOR (0),
    .RAS_DEPTH    (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .signext       (signext),
    .branch        (branch),
    .branch_ne     (branch_ne),
    .alu_zero      (alu_zero),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .ret_target    (ret_target),
    .pc            (pc),
    .pc_next       (pc_next),
    .link_addr     (link_addr),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check pc_next, queue the expectation, clock once, pop and compare.
  task automatic step(input string tag, input logic [15:0] exp_pc);
    exp_t e;
    #1;
    check({tag, "/pc_next"}, 32'(pc_next), 32'(exp_pc));
    e.tag = tag;
    e.pc  = exp_pc;
    e.ovf = exp_ovf;
    e.unf = exp_unf;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, "/pc"},  32'(pc),            32'(e.pc));
    check({e.tag, "/ovf"}, 32'(ras_overflow),  32'(e.ovf));
    check({e.tag, "/unf"}, 32'(ras_underflow), 32'(e.unf));
  endtask

  task automatic idle_inputs();
    stall = 1'b0; signext = '0; branch = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0; jump_target = '0; ret_target = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // 1: reset then free-running increment
    step("reset", 16'h0000);
    reset = 1'b0;
    step("inc1", 16'h0002);
    step("inc2", 16'h0004);
    step("inc3", 16'h0006);

    // 2: beq not taken, beq taken, bne taken with negative offset
    branch = 1'b1; alu_zero = 1'b0;
    step("beq_nt", 16'h0008);
    signext = 16'd6; alu_zero = 1'b1;
    step("beq_t", 16'd22);
    branch = 1'b0; branch_ne = 1'b1; alu_zero = 1'b0; signext = 16'hFFFD;
    step("bne_neg", 16'd18);

    // 3: stall holds across a taken branch, then branch resolves
    branch_ne = 1'b0; branch = 1'b1; alu_zero = 1'b1; signext = 16'd6; stall = 1'b1;
    step("stall1", 16'd18);
    step("stall2", 16'd18);
    stall = 1'b0;
    step("stall_rel", 16'd32);

    // 4: call from 0x20 then return
    idle_inputs();
    call = 1'b1; jump_target = 16'h0100;
    #1;
    check("link_addr", 32'(link_addr), 32'h22);
    step("call", 16'h0100);
    call = 1'b0; ret = 1'b1; ret_target = 16'h0040;
    step("ret", RAS ? 16'h0022 : 16'h0040);
    ret = 1'b0;

    // beq and bne together, alu_zero=0: beq governs so not taken
    branch = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0; signext = 16'd6;
    step("beq_prio", RAS ? 16'h0024 : 16'h0042);

    // jump beats a taken branch
    branch_ne = 1'b0; alu_zero = 1'b1; jump = 1'b1; jump_target = 16'h0200;
    step("jump", 16'h0200);
    idle_inputs();

    // 5: five nested calls then five returns
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; jump_target = 16'h0300 + 16'(i * 16);
      if (RAS && i == 4) exp_ovf = 1'b1;
      step($sformatf("ncall%0d", i), 16'h0300 + 16'(i * 16));
    end
    call = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1; ret_target = 16'h0500;
      if (RAS && i == 4) exp_unf = 1'b1;
      step($sformatf("nret%0d", i),
           (RAS && i < 4) ? 16'h0332 - 16'(i * 16) : 16'h0500);
    end

    // call with ret: ret wins, no push (a later ret still falls back)
    call = 1'b1; jump_target = 16'h0700; ret = 1'b1; ret_target = 16'h0080;
    step("call_ret", 16'h0080);
    call = 1'b0; ret_target = 16'h0090;
    step("ret_after", 16'h0090);

    // stalled call has no side effect
    ret = 1'b0; stall = 1'b1; call = 1'b1; jump_target = 16'h0700;
    step("stall_call", 16'h0090);
    stall = 1'b0; call = 1'b0; ret = 1'b1; ret_target = 16'h00A0;
    step("ret_nopush", 16'h00A0);
    ret = 1'b0;

    // 6: wrap-around
    jump = 1'b1; jump_target = 16'hFFFE;
    step("to_top", 16'hFFFE);
    jump = 1'b0;
    step("wrap", 16'h0000);

    // reset with call: pc to vector, flags cleared, nothing pushed
    jump = 1'b1; jump_target = 16'h0040;
    step("pre_rst", 16'h0040);
    jump = 1'b0; reset = 1'b1; call = 1'b1; jump_target = 16'h0100;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    step("rst_call", 16'h0000);
    reset = 1'b0; call = 1'b0; ret = 1'b1; ret_target = 16'h0060;
    if (RAS) exp_unf = 1'b1;
    step("rst_empty", 16'h0060);
    ret = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
